// File: rtl/flght_mix_pd.sv
// Flight PD controller + motor mixer: per inertial sample, pitch/roll/yaw PD
// corrections are mixed with thrust into four saturated 11-bit motor speeds.
// Latency 3 cycles vld -> spd_vld; fully pipelined, accepts vld every cycle,
// no backpressure.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   vld                 one-cycle strobe, new attitude sample valid
//   ptch/roll/yaw       signed actual attitude (16b)
//   d_ptch/d_roll/d_yaw signed desired attitude (16b)
//   thrst               unsigned thrust (9b)
//   inertial_cal        calibration in progress: speeds forced to CAL_SPEED
//   frnt/bck/lft/rght_spd  unsigned motor speeds (11b)
//   spd_vld             one-cycle pulse when speeds are updated
//   spd_sat             (only with SPD_SAT_FLAG_EN) any motor clamped on this update
//
// Optional feature macro: SPD_SAT_FLAG_EN adds the spd_sat output.
module flght_mix_pd #(
  parameter int          D_QUEUE_DEPTH = 14,
  parameter logic [12:0] MIN_RUN_SPEED = 13'h2C0,
  parameter logic [10:0] CAL_SPEED     = 11'h1B0,
  parameter int          D_COEFF       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic [8:0]         thrst,
  input  logic               inertial_cal,
  output logic [10:0]        frnt_spd,
  output logic [10:0]        bck_spd,
  output logic [10:0]        lft_spd,
  output logic [10:0]        rght_spd,
`ifdef SPD_SAT_FLAG_EN
  output logic               spd_sat,
`endif
  output logic               spd_vld
);

  localparam logic signed [12:0] D_COEFF_S = 13'(D_COEFF);

  // Axis index: 0 = pitch, 1 = roll, 2 = yaw.
  logic signed [15:0] act [3];
  logic signed [15:0] des [3];

  assign act[0] = ptch;
  assign act[1] = roll;
  assign act[2] = yaw;
  assign des[0] = d_ptch;
  assign des[1] = d_roll;
  assign des[2] = d_yaw;

  function automatic logic signed [9:0] sat10(input logic signed [16:0] x);
    if (x > 17'sd511)
      return 10'sd511;
    else if (x < -17'sd512)
      return 10'h200;
    else
      return x[9:0];
  endfunction

  function automatic logic signed [6:0] sat7(input logic signed [10:0] x);
    if (x > 11'sd63)
      return 7'sd63;
    else if (x < -11'sd64)
      return 7'h40;
    else
      return x[6:0];
  endfunction

  function automatic logic [10:0] clamp_spd(input logic signed [13:0] x);
    if (x < 14'sd0)
      return 11'd0;
    else if (x > 14'sd2047)
      return 11'h7FF;
    else
      return x[10:0];
  endfunction

  // ---------------- Stage 1: error, derivative, history ----------------
  logic signed [9:0]  q [3][D_QUEUE_DEPTH];  // [0] newest, [DEPTH-1] oldest
  logic signed [16:0] err_full [3];
  logic signed [9:0]  err_sat  [3];
  logic signed [10:0] diff_full [3];
  logic signed [6:0]  diff_sat  [3];

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      err_full[a]  = $signed({act[a][15], act[a]}) - $signed({des[a][15], des[a]});
      err_sat[a]   = sat10(err_full[a]);
      diff_full[a] = $signed({err_sat[a][9], err_sat[a]})
                   - $signed({q[a][D_QUEUE_DEPTH-1][9], q[a][D_QUEUE_DEPTH-1]});
      diff_sat[a]  = sat7(diff_full[a]);
    end
  end

  logic signed [9:0] s1_err  [3];
  logic signed [6:0] s1_diff [3];
  logic [8:0]        s1_thrst;
  logic              s1_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_thrst <= '0;
      for (int a = 0; a < 3; a++) begin
        s1_err[a]  <= '0;
        s1_diff[a] <= '0;
        for (int i = 0; i < D_QUEUE_DEPTH; i++) q[a][i] <= '0;
      end
    end else begin
      s1_vld <= vld;
      // Everything in this stage, history included, only advances on a new sample.
      if (vld) begin
        s1_thrst <= thrst;
        for (int a = 0; a < 3; a++) begin
          s1_err[a]  <= err_sat[a];
          s1_diff[a] <= diff_sat[a];
          q[a][0]    <= err_sat[a];
          for (int i = 1; i < D_QUEUE_DEPTH; i++) q[a][i] <= q[a][i-1];
        end
      end
    end
  end

  // ---------------- Stage 2: P + D correction ----------------
  logic signed [12:0] err13  [3];
  logic signed [12:0] diff13 [3];
  logic signed [12:0] cor    [3];

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      err13[a]  = {{3{s1_err[a][9]}}, s1_err[a]};
      diff13[a] = {{6{s1_diff[a][6]}}, s1_diff[a]};
      // P gain of 5/8 built from two arithmetic shifts.
      cor[a]    = (err13[a] >>> 1) + (err13[a] >>> 3) + diff13[a] * D_COEFF_S;
    end
  end

  logic signed [12:0] s2_cor [3];
  logic [8:0]         s2_thrst;
  logic               s2_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_thrst <= '0;
      for (int a = 0; a < 3; a++) s2_cor[a] <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_thrst <= s1_thrst;
      for (int a = 0; a < 3; a++) s2_cor[a] <= cor[a];
    end
  end

  // ---------------- Stage 3: mix and clamp ----------------
  logic signed [13:0] base;
  logic signed [13:0] cor14 [3];
  logic signed [13:0] mix   [4];  // 0 frnt, 1 bck, 2 lft, 3 rght
  logic [10:0]        mix_clamped [4];

  always_comb begin
    base = $signed({5'b0, s2_thrst}) + $signed({1'b0, MIN_RUN_SPEED});
    for (int a = 0; a < 3; a++) cor14[a] = {s2_cor[a][12], s2_cor[a]};
    mix[0] = base - cor14[0] - cor14[2];
    mix[1] = base + cor14[0] - cor14[2];
    mix[2] = base - cor14[1] + cor14[2];
    mix[3] = base + cor14[1] + cor14[2];
    for (int m = 0; m < 4; m++) mix_clamped[m] = clamp_spd(mix[m]);
  end

`ifdef SPD_SAT_FLAG_EN
  logic any_clamp;

  always_comb begin
    any_clamp = 1'b0;
    for (int m = 0; m < 4; m++)
      if (mix[m] < 14'sd0 || mix[m] > 14'sd2047) any_clamp = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      spd_sat <= 1'b0;
    else
      spd_sat <= s2_vld && !inertial_cal && any_clamp;
  end
`endif

  logic [10:0] spd_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spd_vld <= 1'b0;
      for (int m = 0; m < 4; m++) spd_q[m] <= '0;
    end else begin
      spd_vld <= s2_vld;
      // Calibration wins over the mix every cycle it is asserted, result or not.
      if (inertial_cal) begin
        for (int m = 0; m < 4; m++) spd_q[m] <= CAL_SPEED;
      end else if (s2_vld) begin
        for (int m = 0; m < 4; m++) spd_q[m] <= mix_clamped[m];
      end
    end
  end

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];

endmodule

// File: tb/tb_flght_mix_pd.sv
// Self-checking bench for flght_mix_pd: directed test-plan steps plus a
// randomized run, compared every cycle against a behavioural model.
module tb_flght_mix_pd;

  localparam int DEPTH = 14;
  localparam int CAL   = 'h1B0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic signed [15:0] ptch, roll, yaw, d_ptch, d_roll, d_yaw;
  logic [8:0]         thrst;
  logic               inertial_cal;
  logic [10:0]        frnt_spd, bck_spd, lft_spd, rght_spd;
  logic               spd_vld;
`ifdef SPD_SAT_FLAG_EN
  logic               spd_sat;
`endif

  always #5 clk = ~clk;

  flght_mix_pd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .ptch         (ptch),
    .roll         (roll),
    .yaw          (yaw),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .inertial_cal (inertial_cal),
    .frnt_spd     (frnt_spd),
    .bck_spd      (bck_spd),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
`ifdef SPD_SAT_FLAG_EN
    .spd_sat      (spd_sat),
`endif
    .spd_vld      (spd_vld)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int due;
    int spd [4];
    bit sat;
  } exp_t;

  exp_t pend [$];
  int   hist [3][$];   // per axis, index 0 = newest error
  int   exp_spd [4];
  bit   exp_vld;
  bit   exp_sat;

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    for (int a = 0; a < 3; a++) begin
      hist[a].delete();
      for (int i = 0; i < DEPTH; i++) hist[a].push_back(0);
    end
    for (int m = 0; m < 4; m++) exp_spd[m] = 0;
    exp_vld = 1'b0;
    exp_sat = 1'b0;
  endtask

  // Takes the currently applied inputs as one new sample.
  task automatic model_sample();
    int   act [3];
    int   des [3];
    int   c [3];
    int   e, d, base;
    exp_t r;
    act[0] = int'(ptch); act[1] = int'(roll); act[2] = int'(yaw);
    des[0] = int'(d_ptch); des[1] = int'(d_roll); des[2] = int'(d_yaw);
    for (int a = 0; a < 3; a++) begin
      e = clampi(act[a] - des[a], -512, 511);
      d = clampi(e - hist[a][DEPTH-1], -64, 63);
      c[a] = (e >>> 1) + (e >>> 3) + d * 7;
      hist[a].push_front(e);
      void'(hist[a].pop_back());
    end
    base = int'(thrst) + 'h2C0;
    r.spd[0] = base - c[0] - c[2];
    r.spd[1] = base + c[0] - c[2];
    r.spd[2] = base - c[1] + c[2];
    r.spd[3] = base + c[1] + c[2];
    r.sat = 1'b0;
    for (int m = 0; m < 4; m++) begin
      if (r.spd[m] < 0 || r.spd[m] > 2047) r.sat = 1'b1;
      r.spd[m] = clampi(r.spd[m], 0, 2047);
    end
    r.due = cyc + 2;
    pend.push_back(r);
  endtask

  // One clock: apply inputs at the falling edge, update the model at the
  // rising edge, compare at the next falling edge.
  task automatic step(input bit v, input bit cal, input bit rst);
    exp_t r;
    vld          = v;
    inertial_cal = cal;
    rst_n        = rst;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      if (v) model_sample();
      exp_vld = 1'b0;
      exp_sat = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        exp_vld = 1'b1;
        if (!cal) begin
          for (int m = 0; m < 4; m++) exp_spd[m] = r.spd[m];
          exp_sat = r.sat;
        end
      end
      if (cal) for (int m = 0; m < 4; m++) exp_spd[m] = CAL;
    end
    @(negedge clk);
    chk("spd_vld",  32'(spd_vld),  32'(exp_vld));
    chk("frnt_spd", 32'(frnt_spd), exp_spd[0]);
    chk("bck_spd",  32'(bck_spd),  exp_spd[1]);
    chk("lft_spd",  32'(lft_spd),  exp_spd[2]);
    chk("rght_spd", 32'(rght_spd), exp_spd[3]);
`ifdef SPD_SAT_FLAG_EN
    chk("spd_sat",  32'(spd_sat),  32'(exp_sat));
`endif
  endtask

  task automatic set_in(input int p, input int r, input int y,
                        input int dp, input int dr, input int dy, input int t);
    ptch = 16'(p); roll = 16'(r); yaw = 16'(y);
    d_ptch = 16'(dp); d_roll = 16'(dr); d_yaw = 16'(dy);
    thrst = 9'(t);
  endtask

  function automatic logic signed [15:0] rnd_att();
    if ($urandom_range(0, 2) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 1400)) - 700);
  endfunction

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    vld = 1'b0; inertial_cal = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_frnt", 32'(frnt_spd), 0);

    // Neutral attitude, one pulse
    set_in(0, 0, 0, 0, 0, 0, 'h100);
    step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("t1_vld",  32'(spd_vld),  1);
    chk("t1_frnt", 32'(frnt_spd), 'h3C0);
    chk("t1_rght", 32'(rght_spd), 'h3C0);
    step(0, 0, 1);
    chk("t1_vld_drop", 32'(spd_vld), 0);

    // Pitch error from fresh reset
    step(0, 0, 0);
    set_in(100, 0, 0, 0, 0, 0, 'h100);
    step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("t2_frnt", 32'(frnt_spd), 'h1C9);
    chk("t2_bck",  32'(bck_spd),  'h5B7);
    chk("t2_lft",  32'(lft_spd),  'h3C0);
    step(0, 0, 1);

    // Clamping at the top
    step(0, 0, 0);
    set_in(0, -32768, 32767, 0, 0, 0, 'h1FF);
    step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("t3_lft",  32'(lft_spd),  2047);
    chk("t3_rght", 32'(rght_spd), 1206);
    chk("t3_frnt", 32'(frnt_spd), 456);
    chk("t3_bck",  32'(bck_spd),  456);
`ifdef SPD_SAT_FLAG_EN
    chk("t3_sat",  32'(spd_sat),  1);
`endif
    step(0, 0, 1);

    // History depth: pulse 15 sees pulse 1's error as its oldest sample
    step(0, 0, 0);
    set_in(100, 0, 0, 0, 0, 0, 'h100);
    for (int k = 1; k <= 15; k++) begin
      step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
      chk($sformatf("t4_frnt_p%0d", k), 32'(frnt_spd), (k <= 14) ? 457 : 898);
      step(0, 0, 1);
    end

    // Calibration override
    set_in(100, 0, 0, 0, 0, 0, 'h100);
    step(1, 1, 1);
    chk("t5_cal_frnt", 32'(frnt_spd), 'h1B0);
    step(0, 1, 1); step(0, 1, 1);
    chk("t5_cal_vld", 32'(spd_vld), 1);
    chk("t5_cal_bck", 32'(bck_spd), 'h1B0);
    step(0, 0, 1);
    chk("t5_hold_lft", 32'(lft_spd), 'h1B0);

    // Randomized traffic, including back-to-back strobes and calibration
    for (int n = 0; n < 300; n++) begin
      ptch = rnd_att(); roll = rnd_att(); yaw = rnd_att();
      d_ptch = rnd_att(); d_roll = rnd_att(); d_yaw = rnd_att();
      thrst = 9'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'b1);
    end
    for (int n = 0; n < 4; n++) step(0, 0, 1);

    // Reset while a sample is in flight
    set_in(100, 20, -30, 0, 0, 0, 'h80);
    step(1, 0, 1);
    step(0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      step(0, 0, 1);
      chk("t6_no_vld", 32'(spd_vld), 0);
    end
    chk("t6_frnt", 32'(frnt_spd), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
